// File: rtl/lb_sched.sv
// Loopback scheduler: PCS RX decoded words -> elastic FIFO -> PCS TX encoder.
// Absorbs RX valid gaps and TX ready gaps with idle insertion/deletion, brings
// the link up from signal_ok and makes sure TX only sees whole frames or an
// explicit ERROR block.
module lb_sched #(
   parameter int IS_10G     = 1,
   parameter int DATA_W     = 64,
   parameter int KEEP_W     = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int LOW_WM     = 2,
   parameter int HIGH_WM    = 6,
   parameter int LOCK_CNT   = 64,
   localparam int LANE0_CNT_N = (IS_10G != 0) ? 2 : 1
) (
   input  logic                   clk,
   input  logic                   nreset,
   input  logic                   rx_signal_ok_i,
   input  logic                   rx_valid_i,
   input  logic                   rx_ctrl_i,
   input  logic                   rx_idle_i,
   input  logic                   rx_term_i,
   input  logic                   rx_err_i,
   input  logic [LANE0_CNT_N-1:0] rx_start_i,
   input  logic [KEEP_W-1:0]      rx_keep_i,
   input  logic [DATA_W-1:0]      rx_data_i,
   input  logic                   tx_ready_i,
   output logic                   tx_ctrl_o,
   output logic                   tx_idle_o,
   output logic                   tx_term_o,
   output logic                   tx_err_o,
   output logic [LANE0_CNT_N-1:0] tx_start_o,
   output logic [KEEP_W-1:0]      tx_keep_o,
   output logic [DATA_W-1:0]      tx_data_o,
   output logic                   link_up_o,
   output logic                   ovf_o,
   output logic                   unf_o,
   input  logic                   clr_i
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LCK_W = $clog2(LOCK_CNT) + 1;
   localparam int WRD_W = 4 + LANE0_CNT_N + KEEP_W + DATA_W;

   localparam logic [PTR_W:0] CNT_LOW  = (PTR_W+1)'(LOW_WM);
   localparam logic [PTR_W:0] CNT_HIGH = (PTR_W+1)'(HIGH_WM);
   localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [LCK_W-1:0] LOCK_LAST = LCK_W'(LOCK_CNT - 1);

   typedef struct packed {
      logic                   ctrl;
      logic                   idle;
      logic [LANE0_CNT_N-1:0] start;
      logic                   term;
      logic                   err;
      logic [KEEP_W-1:0]      keep;
      logic [DATA_W-1:0]      data;
   } word_t;

   localparam word_t W_IDLE = word_t'({2'b11, {(WRD_W-2){1'b0}}});
   localparam word_t W_ERR  = word_t'({2'b10, {LANE0_CNT_N{1'b0}}, 2'b01,
                                       {(KEEP_W+DATA_W){1'b0}}});

   typedef enum logic [1:0] {DOWN, WAIT, LOOP, ABORT} state_t;

   state_t            state, state_nxt;
   logic [LCK_W-1:0]  lock_cnt, lock_nxt;
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [PTR_W:0]    count;
   logic              in_frame, in_frame_nxt;
   word_t             mem [FIFO_DEPTH];
   word_t             tx_q, tx_nxt;
   word_t             rx_w, head;
   logic              droppable, in_loop, full;
   logic              push_try, push, pop, flush, abort_fire;
   logic              ovf_set, unf_set;

   assign rx_w = '{ctrl: rx_ctrl_i, idle: rx_idle_i, start: rx_start_i,
                   term: rx_term_i, err: rx_err_i, keep: rx_keep_i,
                   data: rx_data_i};
   assign head = mem[rd_ptr];

   // FIFO control: idle deletion, pop gating on watermark / in-frame, flags
   always_comb begin
      droppable  = rx_w.ctrl & rx_w.idle & ~(|rx_w.start) & ~rx_w.term & ~rx_w.err;
      in_loop    = (state == LOOP);
      full       = (count == CNT_FULL);
      abort_fire = (state == ABORT) & tx_ready_i;
      flush      = (state == DOWN) | abort_fire;
      push_try   = in_loop & rx_valid_i & ~(droppable & (count >= CNT_HIGH));
      pop        = in_loop & tx_ready_i & (count != '0) &
                   (in_frame | (count >= CNT_LOW));
      // a full FIFO still accepts a word when the head leaves this cycle
      push       = push_try & (~full | pop);
      ovf_set    = push_try & full & ~pop;
      unf_set    = in_loop & tx_ready_i & ~pop & in_frame;
   end

   // Frame tracking and next TX word (outputs only advance on ready cycles)
   always_comb begin
      in_frame_nxt = in_frame;
      tx_nxt       = tx_q;
      if (flush) begin
         in_frame_nxt = 1'b0;
      end else if (pop) begin
         // term wins over start so a single-word frame leaves in_frame clear
         if (head.term)
            in_frame_nxt = 1'b0;
         else if (|head.start)
            in_frame_nxt = 1'b1;
      end else if (unf_set) begin
         in_frame_nxt = 1'b0;
      end
      if (tx_ready_i) begin
         case (state)
            LOOP:    tx_nxt = pop ? head : (in_frame ? W_ERR : W_IDLE);
            ABORT:   tx_nxt = W_ERR;
            default: tx_nxt = W_IDLE;
         endcase
      end
   end

   // Link bring-up sequencing; the first ok cycle in DOWN already counts
   always_comb begin
      state_nxt = state;
      lock_nxt  = lock_cnt;
      case (state)
         DOWN: begin
            lock_nxt = '0;
            if (rx_signal_ok_i) begin
               state_nxt = WAIT;
               lock_nxt  = LCK_W'(1);
            end
         end
         WAIT: begin
            if (!rx_signal_ok_i) begin
               state_nxt = DOWN;
               lock_nxt  = '0;
            end else if (lock_cnt >= LOCK_LAST) begin
               state_nxt = LOOP;
            end else begin
               lock_nxt = lock_cnt + LCK_W'(1);
            end
         end
         LOOP: begin
            // decide on the post-pop frame state so a start leaving this
            // cycle is still closed by an ERROR, and a term leaving is not
            if (!rx_signal_ok_i)
               state_nxt = in_frame_nxt ? ABORT : DOWN;
         end
         ABORT: begin
            if (tx_ready_i)
               state_nxt = DOWN;
         end
         default: state_nxt = DOWN;
      endcase
   end

   // Control registers: FSM, lock counter, frame flag, TX word, sticky flags
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state    <= DOWN;
         lock_cnt <= '0;
         in_frame <= 1'b0;
         tx_q     <= W_IDLE;
         ovf_o    <= 1'b0;
         unf_o    <= 1'b0;
      end else begin
         state    <= state_nxt;
         lock_cnt <= lock_nxt;
         in_frame <= in_frame_nxt;
         tx_q     <= tx_nxt;
         ovf_o    <= ovf_set | (ovf_o & ~clr_i);
         unf_o    <= unf_set | (unf_o & ~clr_i);
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // FIFO storage, no reset needed: occupancy guards every read
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= rx_w;
   end

   assign tx_ctrl_o  = tx_q.ctrl;
   assign tx_idle_o  = tx_q.idle;
   assign tx_start_o = tx_q.start;
   assign tx_term_o  = tx_q.term;
   assign tx_err_o   = tx_q.err;
   assign tx_keep_o  = tx_q.keep;
   assign tx_data_o  = tx_q.data;
   assign link_up_o  = (state == LOOP);

endmodule

// File: tb/tb_lb_sched.sv
// Directed bench for lb_sched: bring-up, pass-through, idle deletion,
// gearbox gaps, underrun, abort and async reset.
module tb_lb_sched;

   typedef logic [77:0] w_t;   // {ctrl, idle, start[1:0], term, err, keep, data}

   logic        clk = 1'b0;
   logic        nreset;
   logic        rx_signal_ok_i, rx_valid_i;
   logic        rx_ctrl_i, rx_idle_i, rx_term_i, rx_err_i;
   logic [1:0]  rx_start_i;
   logic [7:0]  rx_keep_i;
   logic [63:0] rx_data_i;
   logic        tx_ready_i;
   logic        tx_ctrl_o, tx_idle_o, tx_term_o, tx_err_o;
   logic [1:0]  tx_start_o;
   logic [7:0]  tx_keep_o;
   logic [63:0] tx_data_o;
   logic        link_up_o, ovf_o, unf_o, clr_i;

   lb_sched dut (
      .clk(clk), .nreset(nreset), .rx_signal_ok_i(rx_signal_ok_i),
      .rx_valid_i(rx_valid_i), .rx_ctrl_i(rx_ctrl_i), .rx_idle_i(rx_idle_i),
      .rx_term_i(rx_term_i), .rx_err_i(rx_err_i), .rx_start_i(rx_start_i),
      .rx_keep_i(rx_keep_i), .rx_data_i(rx_data_i), .tx_ready_i(tx_ready_i),
      .tx_ctrl_o(tx_ctrl_o), .tx_idle_o(tx_idle_o), .tx_term_o(tx_term_o),
      .tx_err_o(tx_err_o), .tx_start_o(tx_start_o), .tx_keep_o(tx_keep_o),
      .tx_data_o(tx_data_o), .link_up_o(link_up_o), .ovf_o(ovf_o),
      .unf_o(unf_o), .clr_i(clr_i)
   );

   always #5 clk = ~clk;

   w_t txw;
   assign txw = {tx_ctrl_o, tx_idle_o, tx_start_o, tx_term_o, tx_err_o, tx_keep_o, tx_data_o};

   int total = 0;
   int bad   = 0;
   w_t exp_q[$];
   w_t seen[$];
   w_t src[$];
   bit mon_en = 0;
   bit col_en = 0;
   int idle_run = 0;
   int start_idles = -1;

   function automatic w_t mk(input logic c, input logic i, input logic [1:0] s,
                             input logic t, input logic e, input logic [7:0] k,
                             input logic [63:0] d);
      return {c, i, s, t, e, k, d};
   endfunction

   w_t W_IDLE, W_ERR;

   task automatic chk(input string tag, input w_t got, input w_t exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // one clock: drive inputs, take the edge, observe outputs 1ns later
   task automatic tick(input logic v, input w_t w, input logic r);
      rx_valid_i = v;
      {rx_ctrl_i, rx_idle_i, rx_start_i, rx_term_i, rx_err_i, rx_keep_i, rx_data_i} = w;
      tx_ready_i = r;
      if (mon_en && v && (w != W_IDLE)) exp_q.push_back(w);
      @(posedge clk);
      #1;
      if (r) begin
         if (txw == W_IDLE) idle_run++;
         else begin
            if (txw[75:74] != 2'b00) start_idles = idle_run;
            idle_run = 0;
            if (col_en) seen.push_back(txw);
            if (mon_en) begin
               if (exp_q.size() == 0) chk("extra_word", txw, W_IDLE);
               else chk("word", txw, exp_q.pop_front());
            end
         end
      end
   endtask

   w_t st, dw, tm, held;
   w_t arr [6];

   initial begin
      W_IDLE = mk(1, 1, 2'b00, 0, 0, 8'h00, 64'h0);
      W_ERR  = mk(1, 0, 2'b00, 0, 1, 8'h00, 64'h0);
      nreset = 0; rx_signal_ok_i = 0; clr_i = 0;
      rx_valid_i = 0; tx_ready_i = 0;
      {rx_ctrl_i, rx_idle_i, rx_start_i, rx_term_i, rx_err_i, rx_keep_i, rx_data_i} = W_IDLE;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_link", w_t'(link_up_o), w_t'(0));
      chk("rst_ovf",  w_t'(ovf_o), w_t'(0));
      chk("rst_unf",  w_t'(unf_o), w_t'(0));
      chk("rst_tx",   txw, W_IDLE);
      nreset = 1;
      repeat (2) tick(0, W_IDLE, 1);

      // bring-up, interrupted at 30 cycles, then a clean 64-cycle lock
      rx_signal_ok_i = 1;
      repeat (30) tick(1, W_IDLE, 1);
      rx_signal_ok_i = 0;
      repeat (2) tick(1, W_IDLE, 1);
      chk("bu_drop", w_t'(link_up_o), w_t'(0));
      rx_signal_ok_i = 1;
      repeat (63) tick(1, W_IDLE, 1);
      chk("bu_63", w_t'(link_up_o), w_t'(0));
      tick(1, W_IDLE, 1);
      chk("bu_64", w_t'(link_up_o), w_t'(1));
      chk("bu_tx", txw, W_IDLE);

      // pass-through
      mon_en = 1;
      repeat (4) tick(1, W_IDLE, 1);
      tick(1, mk(1, 0, 2'b01, 0, 0, 8'hFF, 64'h0123456789ABCDEF), 1);
      tick(1, mk(0, 0, 2'b00, 0, 0, 8'hFF, 64'h1111111111111111), 1);
      tick(1, mk(0, 0, 2'b00, 0, 0, 8'hFF, 64'h2222222222222222), 1);
      tick(1, mk(0, 0, 2'b00, 0, 0, 8'hFF, 64'h3333333333333333), 1);
      tick(1, mk(1, 0, 2'b00, 1, 0, 8'h0F, 64'h00000000DEADBEEF), 1);
      repeat (6) tick(1, W_IDLE, 1);
      chk("pass_drain", w_t'(exp_q.size()), w_t'(0));

      // idle deletion: FIFO holds 2 idles, 4 more fit before the high mark
      repeat (6) tick(1, W_IDLE, 0);
      tick(1, mk(1, 0, 2'b10, 0, 0, 8'hFF, 64'hA0A0A0A0A0A0A0A0), 0);
      tick(1, mk(0, 0, 2'b00, 0, 0, 8'hFF, 64'hA1A1A1A1A1A1A1A1), 0);
      idle_run = 0;
      start_idles = -1;
      tick(1, mk(0, 0, 2'b00, 0, 0, 8'hFF, 64'hA2A2A2A2A2A2A2A2), 1);
      tick(1, mk(1, 0, 2'b00, 1, 0, 8'h03, 64'h000000000000A3A3), 1);
      repeat (10) tick(1, W_IDLE, 1);
      chk("del_idles", w_t'(start_idles), w_t'(6));
      chk("del_ovf", w_t'(ovf_o), w_t'(0));
      chk("del_drain", w_t'(exp_q.size()), w_t'(0));

      // gearbox gaps on both sides, 10 frames of 20 words
      for (int f = 0; f < 10; f++) begin
         repeat (3) src.push_back(W_IDLE);
         src.push_back(mk(1, 0, 2'b01, 0, 0, 8'hFF, {32'(f), $urandom}));
         for (int k = 0; k < 18; k++)
            src.push_back(mk(0, 0, 2'b00, 0, 0, 8'hFF, {$urandom, $urandom}));
         src.push_back(mk(1, 0, 2'b00, 1, 0, 8'h7F, {$urandom, $urandom}));
      end
      for (int c = 0; c < 2000 && src.size() > 0; c++) begin
         if ((c % 32) != 31) tick(1, src.pop_front(), (c % 33) != 32);
         else tick(0, W_IDLE, (c % 33) != 32);
      end
      repeat (20) tick(1, W_IDLE, 1);
      chk("gap_src", w_t'(src.size()), w_t'(0));
      chk("gap_drain", w_t'(exp_q.size()), w_t'(0));
      chk("gap_ovf", w_t'(ovf_o), w_t'(0));
      chk("gap_unf", w_t'(unf_o), w_t'(0));

      // underrun mid-frame
      mon_en = 0;
      col_en = 1;
      seen.delete();
      repeat (8) tick(1, W_IDLE, 1);
      st = mk(1, 0, 2'b01, 0, 0, 8'hFF, 64'h5555555555555555);
      tick(1, st, 1);
      tick(1, mk(0, 0, 2'b00, 0, 0, 8'hFF, 64'h6666666666666666), 1);
      repeat (10) tick(0, W_IDLE, 1);
      tick(1, mk(0, 0, 2'b00, 0, 0, 8'hFF, 64'h7777777777777777), 1);
      tick(1, mk(0, 0, 2'b00, 0, 0, 8'hFF, 64'h8888888888888888), 1);
      tick(1, mk(1, 0, 2'b00, 1, 0, 8'h01, 64'h0000000000000099), 1);
      repeat (10) tick(1, W_IDLE, 1);
      col_en = 0;
      for (int i = 0; i < 6; i++) arr[i] = (i < seen.size()) ? seen[i] : '0;
      chk("unf_cnt", w_t'(seen.size()), w_t'(6));
      chk("unf_w0", arr[0], st);
      chk("unf_w1", arr[1], mk(0, 0, 2'b00, 0, 0, 8'hFF, 64'h6666666666666666));
      chk("unf_err", arr[2], W_ERR);
      chk("unf_w3", arr[3], mk(0, 0, 2'b00, 0, 0, 8'hFF, 64'h7777777777777777));
      chk("unf_w4", arr[4], mk(0, 0, 2'b00, 0, 0, 8'hFF, 64'h8888888888888888));
      chk("unf_w5", arr[5], mk(1, 0, 2'b00, 1, 0, 8'h01, 64'h0000000000000099));
      chk("unf_flag", w_t'(unf_o), w_t'(1));
      chk("unf_ovf", w_t'(ovf_o), w_t'(0));
      clr_i = 1;
      tick(1, W_IDLE, 1);
      clr_i = 0;
      chk("unf_clr", w_t'(unf_o), w_t'(0));

      // abort: signal_ok lost mid-frame while TX is stalled
      repeat (4) tick(1, W_IDLE, 1);
      tick(1, mk(1, 0, 2'b01, 0, 0, 8'hFF, 64'hC0C0C0C0C0C0C0C0), 1);
      dw = mk(0, 0, 2'b00, 0, 0, 8'hFF, 64'hC1C1C1C1C1C1C1C1);
      repeat (8) tick(1, dw, 1);
      held = txw;
      rx_signal_ok_i = 0;
      tick(1, dw, 0);
      chk("ab_link", w_t'(link_up_o), w_t'(0));
      tick(1, dw, 0);
      chk("ab_hold", txw, held);
      tick(0, W_IDLE, 1);
      chk("ab_err", txw, W_ERR);
      for (int i = 0; i < 3; i++) begin
         tick(0, W_IDLE, 1);
         chk("ab_idle", txw, W_IDLE);
      end
      chk("ab_link2", w_t'(link_up_o), w_t'(0));

      // async reset mid-frame
      rx_signal_ok_i = 1;
      repeat (64) tick(1, W_IDLE, 1);
      chk("re_link", w_t'(link_up_o), w_t'(1));
      tick(1, mk(1, 0, 2'b01, 0, 0, 8'hFF, 64'hE0E0E0E0E0E0E0E0), 1);
      tm = mk(0, 0, 2'b00, 0, 0, 8'hFF, 64'hE1E1E1E1E1E1E1E1);
      repeat (6) tick(1, tm, 1);
      chk("pre_rst_tx", txw, tm);
      nreset = 0;
      #2;
      chk("arst_tx", txw, W_IDLE);
      chk("arst_link", w_t'(link_up_o), w_t'(0));
      #2;
      nreset = 1;
      repeat (2) tick(1, W_IDLE, 1);
      chk("arst_link2", w_t'(link_up_o), w_t'(0));
      chk("arst_tx2", txw, W_IDLE);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
